fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter CLKS_PER_BAUD SHALL default to 104; it sets the enabled clock cycles per serial bit, minimum 2.
REQ-003 Parameter DATA_WIDTH SHALL default to 8; it sets the data bits per frame.
REQ-004 Parameter STOP_BITS SHALL default to 1; it sets the stop bits per frame, legal values 1 or 2.
REQ-005 Port i_clk  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-006 Port i_rst_n  input  1  SHALL be the synchronous active-low reset.
REQ-007 Port i_en  input  1  SHALL be the clock enable, shared with the upstream FIFO.
REQ-008 Port i_empty  input  1  SHALL be the FIFO empty flag.
REQ-009 Port i_data  input  DATA_WIDTH  SHALL be the FIFO read data, valid the cycle after the FIFO samples a read.
REQ-010 Port o_rd  output  1  SHALL be the FIFO read strobe.
REQ-011 Port o_tx  output  1  SHALL be the UART serial line, idle high.
REQ-012 Port o_busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, FETCH, LOAD, START, DATA and STOP; each transition occurs only on an edge where i_en=1.
REQ-014 In IDLE with i_empty=0, the FSM SHALL go to FETCH; with i_empty=1 it SHALL stay in IDLE.
REQ-015 o_rd SHALL be high only in FETCH, and only while i_en=1, so there is exactly one read strobe per frame.
REQ-016 FETCH SHALL go to LOAD unconditionally.
REQ-017 LOAD SHALL capture i_data into a DATA_WIDTH shift register and go to START.
REQ-018 Latency: if o_rd is high in cycle N, i_data SHALL be sampled at the end of N+1 and o_tx SHALL first go low in cycle N+2 (no i_en gaps).
REQ-019 A baud counter (width clog2(CLKS_PER_BAUD)) SHALL count 0..CLKS_PER_BAUD-1 in START/DATA/STOP, advance only when i_en=1, and clear on every state entry.
REQ-020 START SHALL drive o_tx=0 for CLKS_PER_BAUD enabled cycles, then go to DATA.
REQ-021 DATA SHALL send bits LSB first, each for CLKS_PER_BAUD enabled cycles, using a bit counter 0..DATA_WIDTH-1; after the last bit it SHALL go to STOP.
REQ-022 STOP SHALL drive o_tx=1 for STOP_BITS*CLKS_PER_BAUD enabled cycles, then go to IDLE.
REQ-023 o_tx SHALL be 1 in IDLE, FETCH and LOAD, and SHALL be registered (glitch-free).
REQ-024 Back-to-back frames: with the FIFO non-empty, the gap from the end of one stop bit to the next start bit SHALL be exactly 3 enabled cycles (IDLE, FETCH, LOAD).
REQ-025 i_empty SHALL be ignored outside IDLE; if the FIFO empties mid-frame, the current frame SHALL still complete.
REQ-026 When i_en=0, all state, counters and o_tx SHALL hold, and o_rd SHALL be 0.
REQ-027 i_data SHALL be ignored outside LOAD.

Reset
REQ-028 When i_rst_n=0 at a clock edge, the FSM SHALL go to IDLE, all counters SHALL clear, and the shift register SHALL clear, regardless of i_en.
REQ-029 Output values under reset SHALL be o_tx=1, o_rd=0, o_busy=0, from the cycle after the reset edge.
REQ-030 A reset mid-frame SHALL abort the frame with the line high the next cycle; the byte is lost and no extra read is issued.
REQ-031 After reset release, the first o_rd SHALL come no earlier than one enabled cycle after IDLE is observed with i_empty=0.

Verification
REQ-032 Single byte: CLKS_PER_BAUD=4, one FIFO entry 0xA5 -> one o_rd pulse, then o_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, then o_busy=0.
REQ-033 Back-to-back: FIFO holds 0x00 and 0xFF -> two frames, two o_rd pulses, and exactly 3 high cycles between the first stop bit and the second start bit.
REQ-034 Clock enable: toggle i_en 1,0 every cycle during the 0x3C frame -> every bit lasts 8 clocks, o_rd is a single high cycle, and the waveform is otherwise identical.
REQ-035 Reset mid-frame: assert i_rst_n=0 during DATA bit 3 -> o_tx=1, o_busy=0 the next cycle; after release with the FIFO empty, o_rd stays 0.
REQ-036 Two stop bits: STOP_BITS=2, CLKS_PER_BAUD=2, byte 0x81 -> o_tx high for 4 cycles after bit 7, and the total frame is 22 cycles.
REQ-037 Empty FIFO: i_empty=1 held for 1000 cycles -> o_rd=0, o_tx=1 and o_busy=0 throughout.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that pulls one byte per frame from an upstream FIFO
module fifo_uart_tx #(
  parameter int CLKS_PER_BAUD = 104,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_empty,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_rd,
  output logic                  o_tx,
  output logic                  o_busy
);
  localparam int CW = $clog2(CLKS_PER_BAUD);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, LOAD = 3'd2, START = 3'd3, DATA = 3'd4, STOP = 3'd5;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BAUD - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  logic [2:0] state;
  logic [CW-1:0] baud;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic baud_done, timing;
  assign baud_done = baud == BAUD_LAST;
  assign timing = state == START || state == DATA || state == STOP;
  assign o_rd = i_en && state == FETCH;
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      o_tx <= 1'b1;
    end else if (i_en) begin
      baud <= timing && !baud_done ? baud + 1'b1 : '0;
      case (state)
        IDLE: if (!i_empty) state <= FETCH;
        FETCH: state <= LOAD;
        LOAD: begin
          shreg <= i_data;
          o_tx <= 1'b0;
          state <= START;
        end
        START: if (baud_done) begin
          o_tx <= shreg[0];
          shreg <= shreg >> 1;
          state <= DATA;
        end
        DATA: if (baud_done) begin
          bit_cnt <= bit_cnt == BIT_LAST ? '0 : bit_cnt + 1'b1;
          o_tx <= bit_cnt == BIT_LAST ? 1'b1 : shreg[0];
          shreg <= shreg >> 1;
          state <= bit_cnt == BIT_LAST ? STOP : DATA;
        end
        STOP: if (baud_done) begin
          bit_cnt <= bit_cnt == STOP_LAST ? '0 : bit_cnt + 1'b1;
          state <= bit_cnt == STOP_LAST ? IDLE : STOP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
